wb_write_buffer: RTL and testbench

//  Write-back buffer directly upstream of the 8x16 register file write port.
//  ALU and memory results are queued as (regsel, data) entries. One entry drains per cycle into the RF write port.
//  Two lookup ports let decode read the youngest pending value for a register, so RF reads stay coherent with queued writes.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_write_buffer_if.sv | 39 +++
 rtl/wb_lookup.sv | 29 ++
 rtl/wb_write_buffer.sv | 74 +++++++
 tb/tb_wb_write_buffer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared sizes and the queue entry layout for the write-back buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic              vld;
    logic [REG_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_buffer_if.sv
// Bundles the enqueue handshake, RF write port, lookup ports and occupancy.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the buffer gates in_valid from the producer.
interface wb_write_buffer_if;
  import wb_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_regsel;
  logic [DATA_W-1:0] in_data;

  logic              rf_write;
  logic [REG_W-1:0]  rf_writeregsel;
  logic [DATA_W-1:0] rf_writedata;

  logic [REG_W-1:0]  lk1_regsel;
  logic              lk1_hit;
  logic [DATA_W-1:0] lk1_data;
  logic [REG_W-1:0]  lk2_regsel;
  logic              lk2_hit;
  logic [DATA_W-1:0] lk2_data;

  logic [CNT_W-1:0]  count;

  // Producer / decode side.
  modport master (
    output in_valid, in_regsel, in_data, lk1_regsel, lk2_regsel,
    input  in_ready, rf_write, rf_writeregsel, rf_writedata,
    input  lk1_hit, lk1_data, lk2_hit, lk2_data, count
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_regsel, in_data, lk1_regsel, lk2_regsel,
    output in_ready, rf_write, rf_writeregsel, rf_writedata,
    output lk1_hit, lk1_data, lk2_hit, lk2_data, count
  );

endinterface

// File: rtl/wb_lookup.sv
// Finds the youngest valid queued entry for a register and returns its data.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module wb_lookup
  import wb_pkg::*;
(
  input  wb_entry_t         entries [DEPTH],
  input  logic [PTR_W-1:0]  tail,
  input  logic [REG_W-1:0]  regsel,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  // Walk from tail-1 backwards; invalid slots mark the region past head, the first match is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      idx = tail - PTR_W'(k);
      if (!hit && entries[idx].vld && (entries[idx].sel == regsel)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_write_buffer.sv
// Queues (regsel, data) results ahead of the RF write port, drains one per cycle, serves forwarding lookups.
// Latency: an entry enqueued into an empty queue is presented to the RF the next cycle, written one edge later.
// Backpressure: in_ready drops only when all entries are occupied; a same-cycle drain does not free a slot.
module wb_write_buffer
  import wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  wb_write_buffer_if.slave bus
);

  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  logic             ready;
  logic             do_enq;
  logic             do_drn;

  // The RF never stalls, so one drain per cycle normally keeps occupancy low;
  // the full check still guards the queue against any burst pattern.
  assign ready  = (cnt != CNT_W'(DEPTH));
  assign do_enq = bus.in_valid & ready;
  assign do_drn = (cnt != '0);

  assign bus.in_ready       = ready;
  assign bus.count          = cnt;
  assign bus.rf_write       = do_drn;
  assign bus.rf_writeregsel = entries[head].sel;
  assign bus.rf_writedata   = entries[head].data;

  // Entry array, pointers and occupancy; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_enq) begin
        entries[tail] <= '{vld: 1'b1, sel: bus.in_regsel, data: bus.in_data};
        tail          <= tail + 1'b1;
      end
      if (do_drn) begin
        entries[head].vld <= 1'b0;
        head              <= head + 1'b1;
      end
      case ({do_enq, do_drn})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  wb_lookup u_lk1 (
    .entries (entries),
    .tail    (tail),
    .regsel  (bus.lk1_regsel),
    .hit     (bus.lk1_hit),
    .data    (bus.lk1_data)
  );

  wb_lookup u_lk2 (
    .entries (entries),
    .tail    (tail),
    .regsel  (bus.lk2_regsel),
    .hit     (bus.lk2_hit),
    .data    (bus.lk2_data)
  );

endmodule

// File: tb/tb_wb_write_buffer.sv
// Self-checking bench for wb_write_buffer against a queue-based reference model.
// Latency: checks outputs at the falling edge after each rising edge.
// Backpressure: model accepts whenever fewer than DEPTH entries are queued.
module tb_wb_write_buffer;
  import wb_pkg::*;

  typedef struct {
    logic [REG_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  ent_t              mq [$];
  logic [DATA_W-1:0] rf_model [8];
  logic [DATA_W-1:0] tb_rf [8] = '{default: '0};

  wb_write_buffer_if bus ();

  wb_write_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT write port.
  always @(posedge clk) begin
    if (bus.rf_write === 1'b1) tb_rf[bus.rf_writeregsel] <= bus.rf_writedata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Advance one cycle and update the model with what the edge commits.
  task automatic tick();
    bit   enq;
    bit   drn;
    ent_t e;
    ent_t h;
    enq    = (rst === 1'b1) && (bus.in_valid === 1'b1) && (mq.size() != DEPTH);
    drn    = (rst === 1'b1) && (mq.size() != 0);
    e.sel  = bus.in_regsel;
    e.data = bus.in_data;
    @(posedge clk);
    if (drn) begin
      h = mq.pop_front();
      rf_model[h.sel] = h.data;
    end
    if (enq) mq.push_back(e);
    @(negedge clk);
  endtask

  function automatic void model_lk(input logic [REG_W-1:0] sel, output logic hit,
                                   output logic [DATA_W-1:0] data);
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].sel == sel) begin
        hit  = 1'b1;
        data = mq[i].data;
      end
    end
  endfunction

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_checks++; if (bus.rf_write !== 1'b0) begin n_fail++; $display("FAIL reset_rf_write got %b exp 0", bus.rf_write); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    n_checks++; if (bus.lk1_hit !== 1'b0 || bus.lk1_data !== '0) begin n_fail++; $display("FAIL reset_lk1 got %b/%h exp 0/0", bus.lk1_hit, bus.lk1_data); end
    n_checks++; if (bus.lk2_hit !== 1'b0 || bus.lk2_data !== '0) begin n_fail++; $display("FAIL reset_lk2 got %b/%h exp 0/0", bus.lk2_hit, bus.lk2_data); end
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_drain();
    bus.lk1_regsel = 3'd3;
    bus.in_valid = 1'b1; bus.in_regsel = 3'd3; bus.in_data = 16'h1234;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.rf_write !== 1'b1) begin n_fail++; $display("FAIL middrain_pre_write got %b exp 1", bus.rf_write); end
    rst = 1'b0;
    #1;
    mq.delete();
    n_checks++; if (bus.rf_write !== 1'b0) begin n_fail++; $display("FAIL middrain_rf_write got %b exp 0", bus.rf_write); end
    n_checks++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL middrain_count got %0d exp 0", bus.count); end
    n_checks++; if (bus.lk1_hit !== 1'b0) begin n_fail++; $display("FAIL middrain_lk1_hit got %b exp 0", bus.lk1_hit); end
    tick();
    n_checks++; if (tb_rf[3] !== rf_model[3]) begin n_fail++; $display("FAIL middrain_rf_r3 got %h exp %h", tb_rf[3], rf_model[3]); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_pass();
    bus.in_valid = 1'b1; bus.in_regsel = 3'd5; bus.in_data = 16'hBEEF;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.rf_write !== 1'b1) begin n_fail++; $display("FAIL single_rf_write got %b exp 1", bus.rf_write); end
    n_checks++; if (bus.rf_writeregsel !== 3'd5) begin n_fail++; $display("FAIL single_sel got %0d exp 5", bus.rf_writeregsel); end
    n_checks++; if (bus.rf_writedata !== 16'hBEEF) begin n_fail++; $display("FAIL single_data got %h exp beef", bus.rf_writedata); end
    n_checks++; if (bus.count !== CNT_W'(1)) begin n_fail++; $display("FAIL single_count1 got %0d exp 1", bus.count); end
    tick();
    n_checks++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL single_count0 got %0d exp 0", bus.count); end
    n_checks++; if (bus.rf_write !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b exp 0", bus.rf_write); end
    n_checks++; if (tb_rf[5] !== 16'hBEEF) begin n_fail++; $display("FAIL single_rf_r5 got %h exp beef", tb_rf[5]); end
  endtask

  task automatic test_full();
    logic [REG_W-1:0] exp_order [$];
    logic [REG_W-1:0] seen [$];
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_regsel = REG_W'(i); bus.in_data = 16'h0100 + 16'(i);
      #1;
      n_checks++; if (bus.in_ready !== (mq.size() != DEPTH)) begin n_fail++; $display("FAIL full_in_ready[%0d] got %b count %0d", i, bus.in_ready, bus.count); end
      n_checks++; if (bus.count !== CNT_W'(mq.size())) begin n_fail++; $display("FAIL full_count[%0d] got %0d exp %0d", i, bus.count, mq.size()); end
      if (mq.size() != DEPTH) exp_order.push_back(REG_W'(i));
      if (bus.rf_write === 1'b1) seen.push_back(bus.rf_writeregsel);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 8 && mq.size() != 0; c++) begin
      if (bus.rf_write === 1'b1) seen.push_back(bus.rf_writeregsel);
      tick();
    end
    n_checks++; if (seen.size() != exp_order.size()) begin n_fail++; $display("FAIL full_drain_len got %0d exp %0d", seen.size(), exp_order.size()); end
    for (int i = 0; i < exp_order.size() && i < seen.size(); i++) begin
      n_checks++; if (seen[i] !== exp_order[i]) begin n_fail++; $display("FAIL full_drain_order[%0d] got r%0d exp r%0d", i, seen[i], exp_order[i]); end
    end
  endtask

  task automatic test_youngest();
    bus.lk1_regsel = 3'd2;
    bus.in_valid = 1'b1; bus.in_regsel = 3'd2; bus.in_data = 16'h0001;
    tick();
    n_checks++; if (bus.lk1_hit !== 1'b1 || bus.lk1_data !== 16'h0001) begin n_fail++; $display("FAIL young_first got %b/%h exp 1/0001", bus.lk1_hit, bus.lk1_data); end
    bus.in_data = 16'h0002;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.lk1_hit !== 1'b1 || bus.lk1_data !== 16'h0002) begin n_fail++; $display("FAIL young_second got %b/%h exp 1/0002", bus.lk1_hit, bus.lk1_data); end
    tick();
    n_checks++; if (bus.lk1_hit !== 1'b0 || bus.lk1_data !== 16'h0000) begin n_fail++; $display("FAIL young_drained got %b/%h exp 0/0000", bus.lk1_hit, bus.lk1_data); end
    n_checks++; if (tb_rf[2] !== 16'h0002) begin n_fail++; $display("FAIL young_rf_r2 got %h exp 0002", tb_rf[2]); end
  endtask

  task automatic test_lookup_timing();
    bus.lk2_regsel = 3'd7;
    bus.in_valid = 1'b1; bus.in_regsel = 3'd7; bus.in_data = 16'hAAAA;
    #1;
    n_checks++; if (bus.lk2_hit !== 1'b0 || bus.lk2_data !== 16'h0000) begin n_fail++; $display("FAIL lktime_same got %b/%h exp 0/0000", bus.lk2_hit, bus.lk2_data); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.lk2_hit !== 1'b1 || bus.lk2_data !== 16'hAAAA) begin n_fail++; $display("FAIL lktime_next got %b/%h exp 1/aaaa", bus.lk2_hit, bus.lk2_data); end
    tick();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.in_regsel = REG_W'(i % 8); bus.in_data = DATA_W'($urandom);
      if (i > 0) begin
        n_checks++; if (bus.count !== CNT_W'(1)) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d exp 1", i, bus.count); end
        n_checks++; if (bus.rf_write !== 1'b1 || bus.rf_writeregsel !== mq[0].sel || bus.rf_writedata !== mq[0].data) begin
          n_fail++; $display("FAIL wrap_write[%0d] got %b r%0d %h exp 1 r%0d %h", i, bus.rf_write, bus.rf_writeregsel, bus.rf_writedata, mq[0].sel, mq[0].data);
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (bus.count !== CNT_W'(0)) begin n_fail++; $display("FAIL wrap_empty got %0d exp 0", bus.count); end
  endtask

  task automatic test_random();
    logic              h1, h2;
    logic [DATA_W-1:0] d1, d2;
    for (int c = 0; c < 300; c++) begin
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_regsel  = REG_W'($urandom_range(0, 7));
      bus.in_data    = DATA_W'($urandom);
      bus.lk1_regsel = REG_W'($urandom_range(0, 7));
      bus.lk2_regsel = REG_W'($urandom_range(0, 7));
      #1;
      model_lk(bus.lk1_regsel, h1, d1);
      model_lk(bus.lk2_regsel, h2, d2);
      n_checks++; if (bus.count !== CNT_W'(mq.size()) || bus.in_ready !== (mq.size() != DEPTH)) begin
        n_fail++; $display("FAIL rand_count[%0d] got %0d/%b exp %0d", c, bus.count, bus.in_ready, mq.size());
      end
      n_checks++; if (bus.rf_write !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_rf_write[%0d] got %b exp %b", c, bus.rf_write, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_checks++; if (bus.rf_writeregsel !== mq[0].sel || bus.rf_writedata !== mq[0].data) begin
          n_fail++; $display("FAIL rand_head[%0d] got r%0d %h exp r%0d %h", c, bus.rf_writeregsel, bus.rf_writedata, mq[0].sel, mq[0].data);
        end
      end
      n_checks++; if (bus.lk1_hit !== h1 || bus.lk1_data !== d1) begin n_fail++; $display("FAIL rand_lk1[%0d] got %b/%h exp %b/%h", c, bus.lk1_hit, bus.lk1_data, h1, d1); end
      n_checks++; if (bus.lk2_hit !== h2 || bus.lk2_data !== d2) begin n_fail++; $display("FAIL rand_lk2[%0d] got %b/%h exp %b/%h", c, bus.lk2_hit, bus.lk2_data, h2, d2); end
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    for (int r = 0; r < 8; r++) begin
      n_checks++; if (tb_rf[r] !== rf_model[r]) begin n_fail++; $display("FAIL rand_rf[%0d] got %h exp %h", r, tb_rf[r], rf_model[r]); end
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) rf_model[r] = '0;
    bus.in_valid   = 1'b0;
    bus.in_regsel  = '0;
    bus.in_data    = '0;
    bus.lk1_regsel = '0;
    bus.lk2_regsel = '0;
    test_reset();
    test_reset_mid_drain();
    test_single_pass();
    test_full();
    test_youngest();
    test_lookup_timing();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
